router_fsm_controller: RTL and testbench
========================================

Name: router_fsm_controller

Overview:
- Packet-sequencing controller for the 1x3 router ingress path.
- Watches the source handshake (pkt_valid, header address on data_in), destination FIFO status and per-port soft resets.
- Generates the state strobes that drive the synchronizer (detect_add, write_enb_reg) and the input register/parity block (lfd_state, ld_state, laf_state, full_state, rst_int_reg), plus busy back-pressure to the source.

Parameters:
CNT_WIDTH, 8, width of the per-port packet counters; used only when ROUTER_PKT_CNT_EN is defined.

Ports:
clocks  input  1  system clock, all state updates on rising edge
resetns  input  1  synchronous active-low reset
pkt_valid  input  1  source packet valid; high from header byte through last payload byte
data_in  input  2  header address bits [1:0]; sampled in DECODE_ADDRESS
parity_done  input  1  parity byte latched by the register block
low_pkt_valid  input  1  pkt_valid fell while a write was held off by FIFO full
fifo_full  input  1  full flag of the addressed FIFO, muxed by the synchronizer
fifo_empty_0/1/2  input  1 each  empty flags of FIFOs 0..2
soft_reset_0/1/2  input  1 each  30-cycle idle timeout flags from the synchronizer
detect_add  output  1  high in DECODE_ADDRESS
lfd_state  output  1  high in LOAD_FIRST_DATA
ld_state  output  1  high in LOAD_DATA
laf_state  output  1  high in LOAD_AFTER_FULL
full_state  output  1  high in FIFO_FULL_STATE
write_enb_reg  output  1  high in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL
rst_int_reg  output  1  high in CHECK_PARITY_ERROR
busy  output  1  high in LFD, LOAD_PARITY, FIFO_FULL_STATE, LAF, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR

Behaviour:
- Clock and reset: single clock clocks; reset resetns is synchronous, active-low, sampled on rising edge.
- Moore FSM, 3-bit state register. All outputs decoded combinationally from the state register; no output latency beyond the state register.
- Reset state: DECODE_ADDRESS (DA); addr_q = 0. Reset outputs: detect_add=1, all other outputs 0.
- addr_q (2 bits) loads data_in when state==DA and pkt_valid=1; it holds in all other states.
- "empty_sel" = fifo_empty_[addr] and "sreset_sel" = soft_reset_[addr]. Here addr = data_in in DA and addr_q elsewhere.
- Transitions, in priority order:
  - sreset_sel=1 in any state other than DA -> DA next cycle; overrides all other conditions.
  - DA: pkt_valid & data_in!=3 & empty_sel -> LFD.
  - DA: pkt_valid & data_in!=3 & !empty_sel -> WAIT_TILL_EMPTY (WTE).
  - DA: data_in==3 or !pkt_valid -> stay in DA; the invalid address is dropped.
  - LFD -> LOAD_DATA (LD) unconditionally.
  - LD: fifo_full -> FIFO_FULL_STATE (FFS); else !pkt_valid -> LOAD_PARITY (LP); else stay.
  - FFS: !fifo_full -> LOAD_AFTER_FULL (LAF); else stay.
  - LAF: parity_done -> DA; else low_pkt_valid -> LP; else -> LD.
  - LP -> CHECK_PARITY_ERROR (CPE) unconditionally.
  - CPE: fifo_full -> FFS; else -> DA.
  - WTE: empty_sel -> LFD; else stay. Exit by soft reset also applies.
- Simultaneous fifo_full and pkt_valid fall in LD: FFS wins; the low_pkt_valid path later resolves via LAF.
- Reset asserted mid-packet: DA next edge regardless of state; addr_q cleared.
- Unused state encodings -> DA next cycle.

Optional Feature:
- Macro ROUTER_PKT_CNT_EN.
- When defined:
  - Adds outputs pkt_cnt_0/1/2 [CNT_WIDTH-1:0].
  - pkt_cnt_[addr_q] increments by 1 on each cycle where state==LP transitions to CPE.
  - Counters saturate at all-ones and do not wrap.
  - Reset value 0. Soft reset does not clear the counters.
- When undefined: the ports and logic are absent; module behaviour is otherwise identical.

Test Plan:
- Reset: resetns=0 for 2 cycles, then 1 -> detect_add=1, busy=0, write_enb_reg=0.
- Normal packet: pkt_valid=1, data_in=2'b01, fifo_empty_1=1; 4 payload cycles; pkt_valid=0 -> state sequence DA,LFD,LD x4,LP,CPE,DA; write_enb_reg high for 5 cycles; rst_int_reg high 1 cycle.
- Busy destination: data_in=2'b10, fifo_empty_2=0 for 5 cycles then 1 -> WTE for 5 cycles with busy=1, then LFD.
- Full stall: in LD, assert fifo_full for 3 cycles with low_pkt_valid=0, parity_done=0 -> FFS x3, full_state=1, busy=1, then LAF then LD.
- Timeout abort: in WTE for port 0, pulse soft_reset_0 -> DA next cycle, busy=0.
- Invalid address: data_in=2'b11, pkt_valid=1 -> remains DA, busy=0. With ROUTER_PKT_CNT_EN, after 3 packets to port 0, pkt_cnt_0=3.

Source files
------------

// File: rtl/router_fsm_controller.sv
// -----------------------------------------------------------------------------
// router_fsm_controller
//
// Packet-sequencing controller for the 1x3 router ingress path. It watches the
// source handshake and destination FIFO status and produces the state strobes
// for the synchronizer and the input register/parity block. It also produces
// busy back-pressure to the source.
//
// Optional feature macro: ROUTER_PKT_CNT_EN
//   When defined, the module gains the CNT_WIDTH parameter and the
//   pkt_cnt_0/1/2 outputs. These are saturating per-port counts of packets
//   that completed LOAD_PARITY.
//
// Ports:
//   clocks          in   system clock; all state updates on the rising edge
//   resetns         in   synchronous active-low reset
//   pkt_valid       in   source packet valid, header through last payload byte
//   data_in[1:0]    in   header destination address, sampled in DECODE_ADDRESS
//   parity_done     in   parity byte latched by the register block
//   low_pkt_valid   in   pkt_valid fell while a write was held off by full
//   fifo_full       in   full flag of the addressed FIFO
//   fifo_empty_0..2 in   empty flags of FIFOs 0..2
//   soft_reset_0..2 in   idle-timeout flags from the synchronizer
//   detect_add      out  DECODE_ADDRESS
//   lfd_state       out  LOAD_FIRST_DATA
//   ld_state        out  LOAD_DATA
//   laf_state       out  LOAD_AFTER_FULL
//   full_state      out  FIFO_FULL_STATE
//   write_enb_reg   out  LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL
//   rst_int_reg     out  CHECK_PARITY_ERROR
//   busy            out  every state except DECODE_ADDRESS and LOAD_DATA
//   pkt_cnt_0..2    out  per-port packet counters (ROUTER_PKT_CNT_EN only)
// -----------------------------------------------------------------------------
module router_fsm_controller
`ifdef ROUTER_PKT_CNT_EN
#(
    parameter int CNT_WIDTH = 8
)
`endif
(
    input  logic       clocks,
    input  logic       resetns,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy
`ifdef ROUTER_PKT_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] pkt_cnt_0,
    output logic [CNT_WIDTH-1:0] pkt_cnt_1,
    output logic [CNT_WIDTH-1:0] pkt_cnt_2
`endif
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] addr_q;
    logic [1:0] addr;
    logic       empty_sel;
    logic       sreset_sel;

    // The header address is only live on data_in during DECODE_ADDRESS.
    // After that, the latched copy selects the port.
    assign addr = (state == DECODE_ADDRESS) ? data_in : addr_q;

    // Address 3 has no FIFO behind it.
    // Its flags read as 0, so it can never look empty or timed out.
    always_comb begin
        empty_sel  = 1'b0;
        sreset_sel = 1'b0;
        case (addr)
            2'd0: begin
                empty_sel  = fifo_empty_0;
                sreset_sel = soft_reset_0;
            end
            2'd1: begin
                empty_sel  = fifo_empty_1;
                sreset_sel = soft_reset_1;
            end
            2'd2: begin
                empty_sel  = fifo_empty_2;
                sreset_sel = soft_reset_2;
            end
            default: begin
                empty_sel  = 1'b0;
                sreset_sel = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clocks) begin
        if (!resetns) begin
            state  <= DECODE_ADDRESS;
            addr_q <= 2'd0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && pkt_valid) begin
                addr_q <= data_in;
            end
        end
    end

    // A soft reset of the selected port aborts any packet in flight.
    // This check comes before the per-state rules.
    always_comb begin
        next_state = state;
        if (state != DECODE_ADDRESS && sreset_sel) begin
            next_state = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS: begin
                    if (pkt_valid && data_in != 2'd3) begin
                        next_state = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: next_state = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full) begin
                        next_state = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        next_state = LOAD_PARITY;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) begin
                        next_state = LOAD_AFTER_FULL;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        next_state = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        next_state = LOAD_PARITY;
                    end else begin
                        next_state = LOAD_DATA;
                    end
                end
                LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY: begin
                    if (empty_sel) begin
                        next_state = LOAD_FIRST_DATA;
                    end
                end
                default: next_state = DECODE_ADDRESS;
            endcase
        end
    end

    always_comb begin
        detect_add    = (state == DECODE_ADDRESS);
        lfd_state     = (state == LOAD_FIRST_DATA);
        ld_state      = (state == LOAD_DATA);
        laf_state     = (state == LOAD_AFTER_FULL);
        full_state    = (state == FIFO_FULL_STATE);
        write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                        (state == LOAD_AFTER_FULL);
        rst_int_reg   = (state == CHECK_PARITY_ERROR);
        busy          = (state == LOAD_FIRST_DATA) || (state == LOAD_PARITY) ||
                        (state == FIFO_FULL_STATE) || (state == LOAD_AFTER_FULL) ||
                        (state == WAIT_TILL_EMPTY) || (state == CHECK_PARITY_ERROR);
    end

`ifdef ROUTER_PKT_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic pkt_done;

    // A packet counts once, at the LOAD_PARITY to CHECK_PARITY_ERROR step.
    // A soft reset taken from LOAD_PARITY therefore does not count the packet.
    assign pkt_done = (state == LOAD_PARITY) && (next_state == CHECK_PARITY_ERROR);

    always_ff @(posedge clocks) begin
        if (!resetns) begin
            pkt_cnt_0 <= '0;
            pkt_cnt_1 <= '0;
            pkt_cnt_2 <= '0;
        end else if (pkt_done) begin
            case (addr_q)
                2'd0: if (pkt_cnt_0 != CNT_MAX) pkt_cnt_0 <= pkt_cnt_0 + CNT_ONE;
                2'd1: if (pkt_cnt_1 != CNT_MAX) pkt_cnt_1 <= pkt_cnt_1 + CNT_ONE;
                2'd2: if (pkt_cnt_2 != CNT_MAX) pkt_cnt_2 <= pkt_cnt_2 + CNT_ONE;
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_router_fsm_controller.sv
// -----------------------------------------------------------------------------
// tb_router_fsm_controller
//
// Self-checking bench for router_fsm_controller.
//
// The bench contains a transaction-level reference model. The model tracks
// which phase of a packet the router is in, and it derives every strobe from
// that phase. A compare process checks the DUT against the model on every
// falling edge. Directed sequences then pin both DUT and model to
// hand-computed strobe patterns. A randomized phase follows.
//
// The counter checks are compiled when ROUTER_PKT_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_router_fsm_controller;

    localparam int CNT_W   = 8;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    // Packed strobe patterns in the order:
    // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
    localparam logic [7:0] P_DA  = 8'b1000_0000;
    localparam logic [7:0] P_LFD = 8'b0100_0001;
    localparam logic [7:0] P_LD  = 8'b0010_0100;
    localparam logic [7:0] P_LAF = 8'b0001_0101;
    localparam logic [7:0] P_FFS = 8'b0000_1001;
    localparam logic [7:0] P_LP  = 8'b0000_0101;
    localparam logic [7:0] P_CPE = 8'b0000_0011;
    localparam logic [7:0] P_WTE = 8'b0000_0001;

    logic       clocks = 1'b0;
    logic       resetns = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [1:0] data_in = 2'd0;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;
    logic       fifo_full = 1'b0;
    logic       fifo_empty_0 = 1'b0;
    logic       fifo_empty_1 = 1'b0;
    logic       fifo_empty_2 = 1'b0;
    logic       soft_reset_0 = 1'b0;
    logic       soft_reset_1 = 1'b0;
    logic       soft_reset_2 = 1'b0;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;
    logic       busy;
`ifdef ROUTER_PKT_CNT_EN
    logic [CNT_W-1:0] pkt_cnt_0;
    logic [CNT_W-1:0] pkt_cnt_1;
    logic [CNT_W-1:0] pkt_cnt_2;
`endif

    int  vectors = 0;
    int  miscompares = 0;
    bit  check_en = 1'b0;

    router_fsm_controller dut (
        .clocks        (clocks),
        .resetns       (resetns),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy)
`ifdef ROUTER_PKT_CNT_EN
        ,
        .pkt_cnt_0     (pkt_cnt_0),
        .pkt_cnt_1     (pkt_cnt_1),
        .pkt_cnt_2     (pkt_cnt_2)
`endif
    );

    always #5 clocks = ~clocks;

    logic [7:0] dut_out;
    assign dut_out = {detect_add, lfd_state, ld_state, laf_state,
                      full_state, write_enb_reg, rst_int_reg, busy};

    // Reference model: packet phase, latched port, and per-port packet counts.
    typedef enum int {PH_IDLE, PH_FIRST, PH_DATA, PH_STALL, PH_RESUME,
                      PH_PARITY, PH_CHECK, PH_WAIT} phase_t;

    phase_t ph = PH_IDLE;
    int     m_port = 0;
    int     m_cnt [3] = '{0, 0, 0};

    function automatic logic [7:0] phase_pattern(input phase_t p);
        logic writing;
        logic stalling;
        writing  = (p == PH_DATA) || (p == PH_PARITY) || (p == PH_RESUME);
        stalling = (p != PH_IDLE) && (p != PH_DATA);
        return {p == PH_IDLE, p == PH_FIRST, p == PH_DATA, p == PH_RESUME,
                p == PH_STALL, writing, p == PH_CHECK, stalling};
    endfunction

    function automatic logic port_flag(input logic [2:0] flags, input int port);
        return (port < 3) ? flags[port] : 1'b0;
    endfunction

    always @(posedge clocks) begin
        int     port;
        logic   emp;
        logic   srs;
        phase_t nxt;
        if (!resetns) begin
            ph     = PH_IDLE;
            m_port = 0;
            m_cnt  = '{0, 0, 0};
        end else begin
            port = (ph == PH_IDLE) ? int'(data_in) : m_port;
            emp  = port_flag({fifo_empty_2, fifo_empty_1, fifo_empty_0}, port);
            srs  = port_flag({soft_reset_2, soft_reset_1, soft_reset_0}, port);
            nxt  = ph;
            if (ph != PH_IDLE && srs) nxt = PH_IDLE;
            else if (ph == PH_IDLE) begin
                if (pkt_valid && data_in != 2'd3) nxt = emp ? PH_FIRST : PH_WAIT;
            end
            else if (ph == PH_FIRST) nxt = PH_DATA;
            else if (ph == PH_DATA) begin
                if (fifo_full) nxt = PH_STALL;
                else if (!pkt_valid) nxt = PH_PARITY;
            end
            else if (ph == PH_STALL) begin
                if (!fifo_full) nxt = PH_RESUME;
            end
            else if (ph == PH_RESUME) nxt = parity_done ? PH_IDLE :
                                            (low_pkt_valid ? PH_PARITY : PH_DATA);
            else if (ph == PH_PARITY) nxt = PH_CHECK;
            else if (ph == PH_CHECK) nxt = fifo_full ? PH_STALL : PH_IDLE;
            else if (ph == PH_WAIT) begin
                if (emp) nxt = PH_FIRST;
            end
            if (ph == PH_IDLE && pkt_valid) m_port = int'(data_in);
            if (ph == PH_PARITY && nxt == PH_CHECK && m_port < 3 && m_cnt[m_port] < CNT_SAT)
                m_cnt[m_port] = m_cnt[m_port] + 1;
            ph = nxt;
        end
    end

    always @(negedge clocks) begin
        if (check_en) begin
            vectors++;
            if (dut_out !== phase_pattern(ph)) begin
                miscompares++;
                $display("[TB] FAIL cycle_strobes t=%0t dut=%b model=%b", $time, dut_out, phase_pattern(ph));
            end
`ifdef ROUTER_PKT_CNT_EN
            vectors++;
            if (int'(pkt_cnt_0) != m_cnt[0] || int'(pkt_cnt_1) != m_cnt[1] || int'(pkt_cnt_2) != m_cnt[2]) begin
                miscompares++;
                $display("[TB] FAIL cycle_counts t=%0t dut=%0d/%0d/%0d model=%0d/%0d/%0d", $time,
                         pkt_cnt_0, pkt_cnt_1, pkt_cnt_2, m_cnt[0], m_cnt[1], m_cnt[2]);
            end
`endif
        end
    end

    // Called at a falling edge. Drives one cycle of inputs and returns at the
    // next falling edge, after the DUT has taken the rising edge.
    task automatic applyStimulus(input logic pv, input logic [1:0] d, input logic ff,
                                 input logic pd, input logic lpv,
                                 input logic [2:0] emp, input logic [2:0] sr);
        resetns       = 1'b1;
        pkt_valid     = pv;
        data_in       = d;
        fifo_full     = ff;
        parity_done   = pd;
        low_pkt_valid = lpv;
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = emp;
        {soft_reset_2, soft_reset_1, soft_reset_0} = sr;
        @(negedge clocks);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp);
        vectors++;
        if (dut_out !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s dut=%b expected=%b", name, dut_out, exp);
        end
        if (phase_pattern(ph) !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s_model model=%b expected=%b", name, phase_pattern(ph), exp);
        end
    endtask

    task automatic doReset(input int cycles);
        resetns   = 1'b0;
        pkt_valid = 1'b0;
        fifo_full = 1'b0;
        {soft_reset_2, soft_reset_1, soft_reset_0} = 3'b000;
        repeat (cycles) @(negedge clocks);
        resetns = 1'b1;
    endtask

    // Sends a minimal packet: header, one payload byte, then parity.
    task automatic sendPacket(input logic [1:0] port);
        logic [2:0] emp;
        emp = 3'b111;
        applyStimulus(1'b1, port, 1'b0, 1'b0, 1'b0, emp, 3'b000);
        applyStimulus(1'b0, port, 1'b0, 1'b0, 1'b0, emp, 3'b000);
        applyStimulus(1'b0, port, 1'b0, 1'b0, 1'b0, emp, 3'b000);
        applyStimulus(1'b0, port, 1'b0, 1'b0, 1'b0, emp, 3'b000);
        applyStimulus(1'b0, port, 1'b0, 1'b0, 1'b0, emp, 3'b000);
    endtask

`ifdef ROUTER_PKT_CNT_EN
    task automatic checkCount(input string name, input logic [CNT_W-1:0] act, input int exp);
        vectors++;
        if (int'(act) != exp) begin
            miscompares++;
            $display("[TB] FAIL %s dut=%0d expected=%0d", name, act, exp);
        end
    endtask
`endif

    initial begin
        @(negedge clocks);
        doReset(2);
        check_en = 1'b1;

        // Reset state
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
        checkOutput("reset_idle", P_DA);

        // Normal packet to port 1 with four payload cycles
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000);
        checkOutput("norm_lfd", P_LFD);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000);
            checkOutput("norm_ld", P_LD);
        end
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000);
        checkOutput("norm_lp", P_LP);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000);
        checkOutput("norm_cpe", P_CPE);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000);
        checkOutput("norm_done", P_DA);

        // Busy destination on port 2, followed by a full stall
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 3'b011, 3'b000);
            checkOutput("wte_hold", P_WTE);
        end
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000);
        checkOutput("wte_to_lfd", P_LFD);
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
        checkOutput("wte_ld", P_LD);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
            checkOutput("stall_ffs", P_FFS);
        end
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
        checkOutput("stall_laf", P_LAF);
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
        checkOutput("stall_ld", P_LD);

        // Full and pkt_valid fall together: full wins, then LAF leads to parity.
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
        checkOutput("simul_ffs", P_FFS);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000);
        checkOutput("simul_laf", P_LAF);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000);
        checkOutput("simul_lp", P_LP);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
        checkOutput("cpe", P_CPE);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
        checkOutput("cpe_full_ffs", P_FFS);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
        checkOutput("ffs_laf", P_LAF);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
        checkOutput("laf_parity_done", P_DA);

        // Timeout abort while waiting on port 0; another port's timeout is ignored.
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
        checkOutput("abort_wte", P_WTE);
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b110);
        checkOutput("abort_other_port", P_WTE);
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001);
        checkOutput("abort_da", P_DA);

        // Invalid address is dropped
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 3'b111, 3'b111);
            checkOutput("invalid_addr", P_DA);
        end

        // Reset in the middle of a packet
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000);
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000);
        checkOutput("mid_ld", P_LD);
        doReset(1);
        checkOutput("mid_reset", P_DA);

`ifdef ROUTER_PKT_CNT_EN
        for (int i = 0; i < 3; i++) sendPacket(2'd0);
        checkCount("cnt0_three", pkt_cnt_0, 3);
        checkCount("cnt1_zero", pkt_cnt_1, 0);
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001);
        checkCount("cnt0_after_soft_reset", pkt_cnt_0, 3);
        for (int i = 0; i < CNT_SAT + 5; i++) sendPacket(2'd2);
        checkCount("cnt2_saturated", pkt_cnt_2, CNT_SAT);
        checkCount("cnt0_unchanged", pkt_cnt_0, 3);
`endif

        // Randomized traffic, checked against the model every cycle
        for (int i = 0; i < 4000; i++) begin
            resetns       = ($urandom_range(99) >= 2);
            pkt_valid     = ($urandom_range(99) < 70);
            data_in       = 2'($urandom_range(3));
            fifo_full     = ($urandom_range(99) < 20);
            parity_done   = ($urandom_range(99) < 15);
            low_pkt_valid = ($urandom_range(99) < 20);
            fifo_empty_0  = ($urandom_range(99) < 50);
            fifo_empty_1  = ($urandom_range(99) < 50);
            fifo_empty_2  = ($urandom_range(99) < 50);
            soft_reset_0  = ($urandom_range(99) < 4);
            soft_reset_1  = ($urandom_range(99) < 4);
            soft_reset_2  = ($urandom_range(99) < 4);
            @(negedge clocks);
        end

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
